// File: rtl/csr_defines.sv
// csr_defines: shared definitions for the Zicsr execution block.
// Holds the csr_exec FSM state enum, the funct3 encodings and the
// address field that marks a CSR as read-only.
package csr_defines;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // addr[11:10] == 2'b11 marks a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  // funct3 x00 (000 / 100) carries no CSR operation
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/reg_defines.sv
// reg_defines: register-file wide constants shared across the core.
// REG_W_END is the MSB index of an architectural register (XLEN-1).
package reg_defines;

  localparam int REG_W_END = 31;

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational new-value computation for Zicsr instructions.
// i_op is funct3[1:0]: 01 write, 10 set bits, 11 clear bits.
module csr_alu
  import reg_defines::*;
(
  input  logic [1:0]         i_op,
  input  logic [REG_W_END:0] i_old,
  input  logic [REG_W_END:0] i_src,
  output logic [REG_W_END:0] o_new
);

  // select the read-modify-write result for the operation
  always_comb begin
    o_new = i_old;
    case (i_op)
      2'b01:   o_new = i_src;
      2'b10:   o_new = i_old | i_src;
      2'b11:   o_new = i_old & ~i_src;
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/csr_exec.sv
// csr_exec: executes one Zicsr instruction against an external CSR file.
// Sequence: IDLE (accept) -> READ (sample csr_rdata) -> WRITE (one-cycle
// csr_wen strobe when the instruction writes) -> RESP (hold result).
// Optional feature: define CSR_EXEC_RO_CHECK_EN to make write-intent
// accesses to read-only CSRs (addr[11:10] == 2'b11) illegal.
//
// Handshakes: a transfer happens on the rising clock edge where valid and
// ready are both high. req_ready is high only in IDLE; resp_valid is high
// only in RESP, and resp_rdata/resp_illegal do not change until the
// resp_valid && resp_ready edge, which returns the block to IDLE.
module csr_exec
  import reg_defines::*;
  import csr_defines::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  logic [11:0]          req_addr,
  input  logic [REG_W_END:0]   req_rs1_data,
  input  logic [4:0]           req_rs1_idx,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_W_END:0]   resp_rdata,
  output logic                 resp_illegal,
  output logic [11:0]          csr_addr,
  output logic                 csr_wen,
  output logic [REG_W_END:0]   csr_wdata,
  input  logic [REG_W_END:0]   csr_rdata,
  output csr_state_e           o_dbg_state
);

  csr_state_e           r_state;
  csr_state_e           w_next_state;

  logic [2:0]           r_funct3;
  logic [11:0]          r_addr;
  logic [REG_W_END:0]   r_rs1_data;
  logic [4:0]           r_rs1_idx;
  logic [REG_W_END:0]   r_old;

  logic                 w_accept;
  logic                 w_write_intent;
  logic                 w_ro_hit;
  logic                 w_illegal;
  logic [REG_W_END:0]   w_src;
  logic [REG_W_END:0]   w_alu_new;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // RW/RWI always write; set/clear forms write only with a nonzero rs1/zimm
  assign w_write_intent = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);

  // immediate forms use the rs1 field as a zero-extended 5-bit zimm
  assign w_src = r_funct3[2] ? {{(REG_W_END - 4){1'b0}}, r_rs1_idx} : r_rs1_data;

`ifdef CSR_EXEC_RO_CHECK_EN
  assign w_ro_hit = w_write_intent && (r_addr[11:10] == CSR_RO_FIELD);
`else
  assign w_ro_hit = 1'b0;
`endif

  assign w_illegal = !f3_is_legal(r_funct3) || w_ro_hit;

  csr_alu u_alu (
    .i_op  (r_funct3[1:0]),
    .i_old (r_old),
    .i_src (w_src),
    .o_new (w_alu_new)
  );

  assign csr_addr    = r_addr;
  assign o_dbg_state = r_state;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // capture the instruction fields on the request handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs1_data <= '0;
      r_rs1_idx  <= '0;
    end else if (w_accept) begin
      r_funct3   <= req_funct3;
      r_addr     <= req_addr;
      r_rs1_data <= req_rs1_data;
      r_rs1_idx  <= req_rs1_idx;
    end
  end

  // sample the CSR file's combinational read data during READ
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   r_old <= '0;
    else if (r_state == ST_READ) r_old <= csr_rdata;
  end

  // next-state and output decode
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    csr_wen      = 1'b0;
    csr_wdata    = '0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = ST_READ;
      end
      ST_READ: begin
        w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        csr_wen      = w_write_intent && !w_illegal;
        csr_wdata    = w_alu_new;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = w_illegal;
        resp_rdata   = w_illegal ? '0 : r_old;
        if (resp_ready) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_exec.sv
// tb_csr_exec: randomized and directed bench for csr_exec.
// A small CSR file lives in the bench (0xB00 reads a free-running mcycle);
// a reference copy of it is updated only by the bench's own model.
module tb_csr_exec;
  import reg_defines::*;
  import csr_defines::*;

  localparam int W = REG_W_END + 1;

`ifdef CSR_EXEC_RO_CHECK_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [11:0]   req_addr;
  logic [W-1:0]  req_rs1_data;
  logic [4:0]    req_rs1_idx;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_rdata;
  logic          resp_illegal;
  logic [11:0]   csr_addr;
  logic          csr_wen;
  logic [W-1:0]  csr_wdata;
  logic [W-1:0]  csr_rdata;
  csr_state_e    dbg_state;

  csr_exec dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_rs1_data (req_rs1_data),
    .req_rs1_idx  (req_rs1_idx),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .csr_addr     (csr_addr),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- CSR file environment ----------------
  logic [W-1:0] csr_file [0:4095];
  logic [W-1:0] ref_file [0:4095];
  logic [W-1:0] mcycle = '0;
  int unsigned  wen_cnt = 0;
  logic         tb_wr = 1'b0;
  logic [11:0]  tb_wr_addr = '0;
  logic [W-1:0] tb_wr_data = '0;

  always @(posedge clock) begin
    mcycle <= mcycle + 1'b1;
    if (csr_wen) begin
      csr_file[csr_addr] <= csr_wdata;
      wen_cnt <= wen_cnt + 1;
    end else if (tb_wr) begin
      csr_file[tb_wr_addr] <= tb_wr_data;
    end
  end

  assign csr_rdata = (csr_addr == 12'hB00) ? mcycle : csr_file[csr_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [11:0] a, input logic [W-1:0] v);
    @(negedge clock);
    tb_wr = 1'b1; tb_wr_addr = a; tb_wr_data = v;
    ref_file[a] = v;
    @(negedge clock);
    tb_wr = 1'b0;
  endtask

  task automatic drive_noise();
    req_valid    = 1'($urandom_range(0, 1));
    req_funct3   = 3'($urandom);
    req_addr     = 12'($urandom);
    req_rs1_data = $urandom;
    req_rs1_idx  = 5'($urandom);
  endtask

  // Issue one instruction, hold resp_ready low for 'hold' RESP cycles,
  // and check every cycle against the reference model.
  task automatic run_txn(input logic [2:0] f3, input logic [11:0] a,
                         input logic [W-1:0] d, input logic [4:0] idx, input int hold);
    logic [1:0]   op;
    logic [W-1:0] src, old_v, new_v, exp_rd;
    logic         wi, ill, exp_wen;
    int unsigned  wen0;
    op      = f3[1:0];
    src     = f3[2] ? W'(idx) : d;
    wi      = (op == 2'b01) || (idx != 5'd0);
    ill     = (op == 2'b00) || (RO_EN && wi && (a[11:10] == 2'b11));
    exp_wen = !ill && wi;

    @(negedge clock);
    check_eq("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_data = d; req_rs1_idx = idx;
    wen0 = wen_cnt;

    // cycle 1: READ
    @(posedge clock); @(negedge clock);
    old_v = (a == 12'hB00) ? mcycle : ref_file[a];
    if (op == 2'b01)      new_v = src;
    else if (op == 2'b10) new_v = old_v | src;
    else                  new_v = old_v & ~src;
    exp_rd = ill ? '0 : old_v;
    exp_q.push_back(exp_rd);
    check_eq("read_state", dbg_state, ST_READ);
    check_eq("read_addr", csr_addr, a);
    check_eq("read_wen", csr_wen, 0);
    check_eq("read_req_ready", req_ready, 0);
    check_eq("read_resp_valid", resp_valid, 0);
    drive_noise();

    // cycle 2: WRITE
    @(posedge clock); @(negedge clock);
    check_eq("write_wen", csr_wen, exp_wen);
    check_eq("write_addr", csr_addr, a);
    if (exp_wen) begin
      check_eq("write_wdata", csr_wdata, new_v);
      ref_file[a] = new_v;
    end
    check_eq("write_req_ready", req_ready, 0);
    drive_noise();

    // cycle 3: RESP
    @(posedge clock); @(negedge clock);
    exp_rd = exp_q.pop_front();
    check_eq("resp_valid", resp_valid, 1);
    check_eq("resp_rdata", resp_rdata, exp_rd);
    check_eq("resp_illegal", resp_illegal, ill);
    check_eq("resp_req_ready", req_ready, 0);
    for (int k = 0; k < hold; k++) begin
      drive_noise();
      @(posedge clock); @(negedge clock);
      check_eq("hold_valid", resp_valid, 1);
      check_eq("hold_rdata", resp_rdata, exp_rd);
      check_eq("hold_illegal", resp_illegal, ill);
      check_eq("hold_req_ready", req_ready, 0);
      check_eq("hold_wen", csr_wen, 0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0;
    check_eq("done_req_ready", req_ready, 1);
    check_eq("done_resp_valid", resp_valid, 0);
    check_eq("wen_pulses", W'(wen_cnt - wen0), W'(exp_wen));
  endtask

  // Start a CSRRW and pull reset while it sits in WRITE.
  task automatic reset_in_write(input logic [11:0] a, input logic [W-1:0] d);
    @(negedge clock);
    check_eq("rst_idle_ready", req_ready, 1);
    req_valid = 1'b1; req_funct3 = CSRRW; req_addr = a; req_rs1_data = d; req_rs1_idx = 5'd1;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    check_eq("rst_pre_wen", csr_wen, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_wen_drop", csr_wen, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_wdata", csr_wdata, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [11:0] addr_list [8];

  initial begin
    addr_list = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h344, 12'hC00, 12'hF11, 12'h7C0};
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_data = '0; req_rs1_idx = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_valid", resp_valid, 0);
    check_eq("rst_illegal", resp_illegal, 0);
    check_eq("rst_csr_wen", csr_wen, 0);
    check_eq("rst_csr_wdata", csr_wdata, 0);
    check_eq("rst_rdata", resp_rdata, 0);
    reset = 1'b0;

    foreach (addr_list[i]) preload(addr_list[i], $urandom);

    // CSRRW write-through, old value returned
    preload(12'h340, 32'h12);
    run_txn(CSRRW, 12'h340, 32'hDEADBEEF, 5'd3, 0);
    // CSRRS x0 of mcycle: read only
    run_txn(CSRRS, 12'hB00, $urandom, 5'd0, 0);
    // CSRRCI zimm=5 on 0xFF
    preload(12'h344, 32'hFF);
    run_txn(CSRRCI, 12'h344, $urandom, 5'd5, 0);
    // illegal funct3
    run_txn(3'b100, 12'h340, $urandom, 5'd7, 0);
    // write to read-only address field
    run_txn(CSRRW, 12'hF11, 32'h1234, 5'd1, 0);
    // back-pressure on the response
    run_txn(CSRRS, 12'h340, '0, 5'd0, 5);
    // reset mid-WRITE discards the write
    reset_in_write(12'h340, 32'h55);
    run_txn(CSRRS, 12'h340, '0, 5'd0, 0);

    // randomized instructions
    for (int n = 0; n < 40; n++) begin
      logic [4:0] ridx;
      ridx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_txn(3'($urandom), addr_list[$urandom_range(0, 7)], $urandom, ridx,
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/csr_exec.md
CSR_EXEC -- requirements
Module: csr_exec

Interface
REQ-001 SHALL have port clock, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1, a Zicsr instruction is offered.
REQ-004 SHALL have port req_ready, output, 1, the block accepts the request.
REQ-005 SHALL have port req_funct3, input, 3, the Zicsr opcode variant.
REQ-006 SHALL have port req_addr, input, 12, the target CSR address.
REQ-007 SHALL have port req_rs1_data, input, REG_W_END+1, the register operand.
REQ-008 SHALL have port req_rs1_idx, input, 5, the rs1 index, also used as zimm.
REQ-009 SHALL have port resp_valid, output, 1, a result is available.
REQ-010 SHALL have port resp_ready, input, 1, the consumer takes the result.
REQ-011 SHALL have port resp_rdata, output, REG_W_END+1, the old CSR value for rd.
REQ-012 SHALL have port resp_illegal, output, 1, the instruction is illegal.
REQ-013 SHALL have port csr_addr, output, 12, the address driven to the CSR file.
REQ-014 SHALL have port csr_wen, output, 1, a single-cycle write strobe.
REQ-015 SHALL have port csr_wdata, output, REG_W_END+1, the write data.
REQ-016 SHALL have port csr_rdata, input, REG_W_END+1, the combinational read data from the CSR file.

Function
REQ-017 SHALL implement the FSM IDLE->READ->WRITE->RESP->IDLE, and SHALL drive req_ready=1 only in IDLE.
REQ-018 SHALL latch funct3, addr, rs1_data and rs1_idx on req_valid&&req_ready, then move to READ.
REQ-019 In READ, SHALL drive csr_addr from the latched address and capture csr_rdata into an old-value register.
REQ-020 In WRITE, SHALL compute new = RW: src; RS: old|src; RC: old&~src.
REQ-021 SHALL use src = rs1_data for funct3 001/010/011 and src = zero-extended rs1_idx for 101/110/111.
REQ-022 In WRITE, SHALL pulse csr_wen for exactly one cycle when the instruction is RW or RWI.
REQ-023 In WRITE, SHALL pulse csr_wen for exactly one cycle when the instruction is RS/RC/RSI/RCI and rs1_idx != 0.
REQ-024 SHALL NOT assert csr_wen when RS/RC/RSI/RCI have rs1_idx == 0.
REQ-025 SHALL treat funct3 000 and 100 as illegal: no write, resp_rdata=0, resp_illegal=1.
REQ-026 In RESP, SHALL hold resp_valid, resp_rdata and resp_illegal stable until resp_ready; the handshake cycle returns to IDLE.
REQ-027 SHALL keep csr_wen=0 and csr_addr=latched address in all states other than WRITE.
REQ-028 SHALL have a fixed latency: accept at cycle 0, READ at 1, WRITE at 2, resp_valid at 3; back-to-back throughput is one instruction per 4 cycles minimum.
REQ-029 SHALL ignore req_valid while not in IDLE.

Reset
REQ-030 On reset, SHALL enter IDLE and clear all latched registers to 0 within the same cycle.
REQ-031 On reset, SHALL drive req_ready=1, resp_valid=0, resp_illegal=0, csr_wen=0, csr_wdata=0, resp_rdata=0.
REQ-032 Reset in any state, including mid-WRITE, SHALL drop csr_wen immediately and discard the in-flight instruction.

Configuration
REQ-033 With CSR_EXEC_RO_CHECK_EN defined, a write-intent access to an address with addr[11:10]==2'b11 SHALL be illegal, with no csr_wen, resp_illegal=1 and resp_rdata=0.
REQ-034 Without CSR_EXEC_RO_CHECK_EN, such writes SHALL be issued normally and resp_illegal SHALL come only from funct3.

Structure
REQ-035 The shared package csr_defines SHALL hold the FSM state enum, the funct3 localparams (CSRRW..CSRRCI) and the read-only address-field constant.
REQ-036 Data width SHALL come from reg_defines::REG_W_END.
REQ-037 The combinational sub-module csr_alu (op, old, src -> new) SHALL compute the write data.

Verification
REQ-038 Bench SHALL check: CSRRW addr 0x340, rs1_data=0xDEADBEEF, csr_rdata=0x12 -> csr_wen pulse at cycle 2 with wdata 0xDEADBEEF; resp_rdata=0x12 at cycle 3.
REQ-039 Bench SHALL check: CSRRS rs1_idx=0, addr 0xB00 -> no csr_wen; resp_rdata = the sampled mcycle low word.
REQ-040 Bench SHALL check: CSRRCI zimm=5, old=0xFF -> wdata 0xFA.
REQ-041 Bench SHALL check: funct3=100 -> resp_illegal=1, resp_rdata=0, no csr_wen.
REQ-042 Bench SHALL check: CSRRW to 0xF11 with the macro -> illegal and no write; without the macro -> csr_wen pulse.
REQ-043 Bench SHALL check: resp_ready held low 5 cycles -> resp outputs stable and req_ready=0; reset asserted in WRITE -> csr_wen=0 at once and req_ready=1.
